wb_regfile: RTL

//  Write-back end of the MEM/WB pipeline interface. Consumes the registered MEM/WB outputs.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/regfile_dump_ctrl.sv | 83 ++++++++
 rtl/wb_regfile.sv | 84 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and dump-engine state encoding for the write-back / register-file slice.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Register-dump engine: streams regs 0..NREGS-1 as valid/ready beats, one beat per accepted transfer.
// Beat data is captured from a bypassed read port, so stalls hold the beat and never stall the pipeline.
module regfile_dump_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int NREGS  = cpu_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      data_q <= data_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    data_nxt   = data_q;
    rd_addr    = ptr + 1'b1;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    dump_busy  = 1'b0;
    case (state)
      IDLE: begin
        rd_addr = '0;
        if (dump_start) begin
          state_nxt = SEND;
          ptr_nxt   = '0;
          data_nxt  = rd_data;
        end
      end
      SEND: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        // The next beat is sampled in the transfer cycle, so a same-cycle write lands in it.
        if (dump_ready) begin
          if (ptr == LAST) begin
            state_nxt = DONE;
          end else begin
            ptr_nxt  = ptr + 1'b1;
            data_nxt = rd_data;
          end
        end
      end
      DONE: begin
        dump_done = 1'b1;
        dump_busy = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dump_addr = ptr;
  assign dump_data = data_q;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and 8x16 register file: zero-latency bypassed read ports plus a debug dump engine.
// The dump stream is valid/ready and holds its beat under backpressure; the pipeline is never stalled.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int NREGS   = cpu_pkg::NREGS,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regwrite_in,
  input  logic              memtoreg_in,
  input  logic [DATA_W-1:0] readdata_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [ADDR_W-1:0] ins_wr_in,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  output logic [DATA_W-1:0] rs1_data,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              we;
  logic [ADDR_W-1:0] dump_rd_addr;
  logic [DATA_W-1:0] dump_rd_data;

  function automatic logic [DATA_W-1:0] bypass_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (R0_ZERO && addr == '0) return '0;
    if (wen && addr == waddr) return wdata;
    return stored;
  endfunction

  assign wb_data = memtoreg_in ? readdata_in : alu_result_in;
  assign we      = regwrite_in & ~(R0_ZERO & (ins_wr_in == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[ins_wr_in] <= wb_data;
    end
  end

  always_comb begin
    rs1_data     = bypass_read(rs1_addr, regs[rs1_addr], we, ins_wr_in, wb_data);
    rs2_data     = bypass_read(rs2_addr, regs[rs2_addr], we, ins_wr_in, wb_data);
    dump_rd_data = bypass_read(dump_rd_addr, regs[dump_rd_addr], we, ins_wr_in, wb_data);
  end

  regfile_dump_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_dump (
    .clk        (clk),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done),
    .rd_addr    (dump_rd_addr),
    .rd_data    (dump_rd_data)
  );

endmodule
